bnn_img_loader: RTL and testbench
=================================

Name: bnn_img_loader

Overview:
- Upstream feeder of the BNN convolution layer.
- Accepts a raster stream of grayscale pixels over a valid/ready handshake and binarizes each pixel against a runtime threshold.
- Assembles a zero-padded square binary frame in a register array; the flat output drives the layer's image-buffer input directly.
- Holds the completed frame and flags it until the consumer acknowledges it.

Parameters:
- IMG_WIDTH, 30, padded frame side length; frame bit (r,c) is img_buf[r*IMG_WIDTH+c].
- PAD, 1, border width of constant padding on each side.
- PIX_WIDTH, 8, input pixel width in bits.
- Derived localparams (not overridable): INNER = IMG_WIDTH-2*PAD (28), NPIX = INNER*INNER (784), CW = $clog2(INNER).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pix_in  input  PIX_WIDTH  unsigned pixel, raster order (row-major, top-left first).
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  loader can accept a pixel this cycle.
- bin_thresh  input  PIX_WIDTH  binarization threshold, sampled at each accept.
- frame_start  input  1  synchronous abort/restart of the current frame.
- frame_ack  input  1  consumer has taken the frame.
- img_buf  output  IMG_WIDTH*IMG_WIDTH  padded binary frame.
- frame_valid  output  1  img_buf holds a complete frame.

Behaviour:
- Reset (async assert on rst_n=0) forces:
  - state=LOAD, row=col=0;
  - img_buf all 0, frame_valid=0, pix_ready=0 while rst_n=0.
- Padding bits (row or col < PAD, or >= PAD+INNER) are constant 0 and are never written.
- Binarize: bit = (pix_in >= bin_thresh), unsigned compare. bin_thresh=0 gives 1 for every pixel.
- pix_ready = (state==LOAD) && !frame_start. This is combinational from registered state; it does not depend on pix_valid.
- Accept means pix_valid && pix_ready at a rising edge. On accept:
  - write the bit to img_buf[(row+PAD)*IMG_WIDTH + col+PAD] at that edge;
  - col increments; at col==INNER-1, col wraps to 0 and row increments.
- States:
  - LOAD:
    - Accepts pixels.
    - An accept at row==col==INNER-1 moves to FULL. frame_valid=1 is registered at the same edge, so latency from the last pixel edge to frame_valid is 0 cycles after that edge.
  - FULL:
    - pix_ready=0; frame_valid=1; img_buf is stable.
    - On frame_ack=1: go to LOAD, row=col=0, frame_valid=0 at that edge.
    - frame_ack in LOAD is ignored.
- frame_start=1 has top priority in any state:
  - next state LOAD, row=col=0, frame_valid=0;
  - no pixel is accepted that cycle.
- Frame contents are never cleared except by reset. Each new frame overwrites every interior bit before frame_valid rises again.
- pix_valid may assert/deassert freely. Gaps stall the counters with no other effect.
- No back-to-back overlap: the next frame's first pixel is accepted no earlier than the cycle after the ack edge.
- Reset mid-frame: everything returns to reset values immediately. A partial frame is discarded.

Decomposition:
- Shared package bnn_pkg holds:
  - the state typedef (LOAD, FULL);
  - the default IMG_WIDTH, PAD and PIX_WIDTH constants, shared with the layer so both sides agree on frame geometry.
- One natural sub-module: bnn_raster_counter.
  - Parameter INNER.
  - Ports: clk, rst_n, clear, advance, row, col, last.
  - last = row==INNER-1 && col==INNER-1.

Test Plan:
- Reset, then stream 784 pixels of 200 with bin_thresh=128, pix_valid held high.
  - pix_ready=1 throughout.
  - frame_valid rises at the 784th accept edge.
  - All 784 interior bits are 1; all 116 border bits are 0; pix_ready=0 afterwards.
- Checkerboard frame: pixel (r,c)=255 if (r+c) odd else 0, bin_thresh=1.
  - img_buf[(r+1)*30+c+1] equals (r+c)&1.
  - Also check the edge case pixel==thresh maps to 1.
- Random pix_valid gaps (~50% duty) over a full frame.
  - Result is identical to the gap-free run.
  - frame_valid rises exactly on the 784th accept.
- In FULL, hold pix_valid=1 for 20 cycles, then frame_ack.
  - No writes and img_buf unchanged while held.
  - pix_ready returns to 1 the cycle after the ack.
  - The second frame of all 0s clears all interior bits.
- After 300 pixels, pulse frame_start coincident with pix_valid.
  - That pixel is not accepted.
  - The next accept writes bit (1,1).
  - frame_valid rises only after 784 further accepts.
- Assert rst_n=0 mid-frame at pixel 500.
  - img_buf=0, frame_valid=0, pix_ready=0 asynchronously.
  - After release, a full frame loads correctly.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared frame geometry and loader state type for the BNN front end.
// The layer imports the same defaults so both sides agree on frame layout.
package bnn_pkg;

    localparam int DEF_IMG_WIDTH = 30;
    localparam int DEF_PAD       = 1;
    localparam int DEF_PIX_WIDTH = 8;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/bnn_raster_counter.sv
// Row/column position within the unpadded interior of a raster frame.
// The row also wraps after the last pixel so the counter idles at the origin.
module bnn_raster_counter #(
    parameter  int INNER = 28,
    localparam int CW    = $clog2(INNER)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    assign last = (row == CW'(INNER - 1)) && (col == CW'(INNER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == CW'(INNER - 1)) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bnn_img_loader.sv
// Binarizing raster loader that assembles a zero-padded square frame
// and holds it for the convolution layer until acknowledged.
module bnn_img_loader
    import bnn_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int PAD       = DEF_PAD,
    parameter int PIX_WIDTH = DEF_PIX_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PIX_WIDTH-1:0]           pix_in,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [PIX_WIDTH-1:0]           bin_thresh,
    input  logic                           frame_start,
    input  logic                           frame_ack,
    output logic [IMG_WIDTH*IMG_WIDTH-1:0] img_buf,
    output logic                           frame_valid
);

    localparam int INNER = IMG_WIDTH - 2 * PAD;
    localparam int NPIX  = INNER * INNER;
    localparam int CW    = $clog2(INNER);
    localparam int IW    = $clog2(NPIX);

    state_t          state, state_next;
    logic [CW-1:0]   row, col;
    logic            last;
    logic            accept;
    logic            clear;
    logic            pix_bit;
    logic [IW-1:0]   wr_idx;
    logic [NPIX-1:0] interior;

    // Gated by rst_n so the handshake stays closed while reset is held.
    assign pix_ready   = rst_n && (state == LOAD) && !frame_start;
    assign accept      = pix_valid && pix_ready;
    assign clear       = frame_start || ((state == FULL) && frame_ack);
    assign pix_bit     = (pix_in >= bin_thresh);
    assign wr_idx      = IW'(row) * IW'(INNER) + IW'(col);
    assign frame_valid = (state == FULL);

    bnn_raster_counter #(
        .INNER(INNER)
    ) u_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .advance(accept),
        .row    (row),
        .col    (col),
        .last   (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = LOAD;
        end else begin
            case (state)
                LOAD:    if (accept && last) state_next = FULL;
                FULL:    if (frame_ack)      state_next = LOAD;
                default: state_next = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            interior <= '0;
        end else if (accept) begin
            interior[wr_idx] <= pix_bit;
        end
    end

    // Border bits are never stored; they are tied to zero here.
    always_comb begin
        img_buf = '0;
        for (int unsigned r = 0; r < INNER; r++) begin
            for (int unsigned c = 0; c < INNER; c++) begin
                img_buf[(r + PAD) * IMG_WIDTH + c + PAD] = interior[r * INNER + c];
            end
        end
    end

endmodule

// File: tb/tb_bnn_img_loader.sv
// Scoreboard bench for bnn_img_loader: expected frames are queued as pixels
// are prepared and compared against img_buf when frame_valid rises.
module tb_bnn_img_loader;

    localparam int W     = 30;
    localparam int P     = 1;
    localparam int INNER = W - 2 * P;
    localparam int NPIX  = INNER * INNER;
    localparam int NBITS = W * W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic [7:0]       bin_thresh;
    logic             frame_start;
    logic             frame_ack;
    logic [NBITS-1:0] img_buf;
    logic             frame_valid;

    int vectors = 0;
    int errors  = 0;
    int pos     = 0;

    logic [7:0]       frame_pix [NPIX];
    logic [NBITS-1:0] sb [$];
    logic [NBITS-1:0] last_frame;

    bnn_img_loader #(
        .IMG_WIDTH(W),
        .PAD      (P),
        .PIX_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .bin_thresh (bin_thresh),
        .frame_start(frame_start),
        .frame_ack  (frame_ack),
        .img_buf    (img_buf),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [NBITS-1:0] model_frame(input logic [7:0] thr);
        logic [NBITS-1:0] f;
        f = '0;
        for (int r = 0; r < INNER; r++)
            for (int c = 0; c < INNER; c++)
                f[(r + P) * W + c + P] = (frame_pix[r * INNER + c] >= thr);
        return f;
    endfunction

    // Feeds n accepted pixels from frame_pix starting at pos; pops the
    // scoreboard when the frame completes.
    task automatic feed(input int n, input logic [7:0] thr, input bit gaps);
        int got = 0;
        int cyc = 0;
        logic [NBITS-1:0] exp;
        int diffs;
        int first;
        while (got < n) begin
            @(negedge clk);
            pix_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_in     = pix_valid ? frame_pix[pos] : 8'($urandom);
            bin_thresh = thr;
            #1;
            vectors++;
            if (pix_ready !== 1'b1) begin
                errors++;
                $display("FAIL pix_ready_load: pos %0d got %b want 1", pos, pix_ready);
            end
            @(posedge clk);
            #1;
            if (pix_valid) begin
                pos++;
                got++;
            end
            vectors++;
            if (frame_valid !== (pos == NPIX)) begin
                errors++;
                $display("FAIL frame_valid_timing: accepts %0d got %b want %b",
                         pos, frame_valid, (pos == NPIX));
            end
            if (pos == NPIX) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: frame completed got 0 queued want 1");
                end else begin
                    exp = sb.pop_front();
                    last_frame = exp;
                    diffs = 0;
                    first = -1;
                    for (int i = 0; i < NBITS; i++) begin
                        if (img_buf[i] !== exp[i]) begin
                            diffs++;
                            if (first < 0) first = i;
                        end
                    end
                    if (diffs != 0) begin
                        errors++;
                        $display("FAIL frame_contents: %0d bits differ, first bit %0d got %b want %b",
                                 diffs, first, img_buf[first], exp[first]);
                    end
                end
            end
            cyc++;
            if (cyc > 8 * n + 100) begin
                errors++;
                $display("FAIL feed_timeout: got %0d accepts want %0d", got, n);
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        pos = 0;
        vectors++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_frame_valid: got %b want 0", frame_valid);
        end
        vectors++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_pix_ready: got %b want 1", pix_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (img_buf !== '0) begin
            errors++;
            $display("FAIL reset_img_buf: got nonzero want 0");
        end
        vectors++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_valid: got %b want 0", frame_valid);
        end
        vectors++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pix_ready: got %b want 0", pix_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_pix_ready: got %b want 1", pix_ready);
        end
        pos = 0;
    endtask

    task automatic test_const_frame();
        int in_ones = 0;
        int border_ones = 0;
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'd200;
        sb.push_back(model_frame(8'd128));
        feed(NPIX, 8'd128, 1'b0);
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++) begin
                if (r < P || c < P || r >= P + INNER || c >= P + INNER)
                    border_ones += int'(img_buf[r * W + c]);
                else
                    in_ones += int'(img_buf[r * W + c]);
            end
        vectors++;
        if (in_ones != NPIX) begin
            errors++;
            $display("FAIL const_interior_ones: got %0d want %0d", in_ones, NPIX);
        end
        vectors++;
        if (border_ones != 0) begin
            errors++;
            $display("FAIL const_border_ones: got %0d want 0", border_ones);
        end
        @(negedge clk);
        vectors++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_pix_ready: got %b want 0", pix_ready);
        end
        do_ack();
    endtask

    task automatic test_checker();
        for (int r = 0; r < INNER; r++)
            for (int c = 0; c < INNER; c++)
                frame_pix[r * INNER + c] = ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
        sb.push_back(model_frame(8'd1));
        feed(NPIX, 8'd1, 1'b0);
        vectors++;
        if (img_buf[(1 + 1) * W + 0 + 1] !== 1'b1 || img_buf[(0 + 1) * W + 0 + 1] !== 1'b0) begin
            errors++;
            $display("FAIL checker_corner: got %b%b want 10",
                     img_buf[(1 + 1) * W + 0 + 1], img_buf[(0 + 1) * W + 0 + 1]);
        end
        do_ack();
    endtask

    task automatic test_thresh_equal();
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom_range(99, 101));
        frame_pix[0] = 8'd100;
        frame_pix[1] = 8'd99;
        sb.push_back(model_frame(8'd100));
        feed(NPIX, 8'd100, 1'b0);
        vectors++;
        if (img_buf[W + 1] !== 1'b1 || img_buf[W + 2] !== 1'b0) begin
            errors++;
            $display("FAIL thresh_equal: got %b%b want 01", img_buf[W + 2], img_buf[W + 1]);
        end
        do_ack();
    endtask

    task automatic test_gaps();
        for (int r = 0; r < INNER; r++)
            for (int c = 0; c < INNER; c++)
                frame_pix[r * INNER + c] = ((r + c) % 2 == 1) ? 8'd255 : 8'd0;
        sb.push_back(model_frame(8'd1));
        feed(NPIX, 8'd1, 1'b1);
    endtask

    task automatic test_hold_full();
        int zeros = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            pix_valid  = 1'b1;
            pix_in     = 8'($urandom);
            bin_thresh = 8'd0;
            #1;
            vectors++;
            if (pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_pix_ready: cycle %0d got %b want 0", k, pix_ready);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (frame_valid !== 1'b1 || img_buf !== last_frame) begin
                errors++;
                $display("FAIL hold_stable: cycle %0d frame_valid got %b want 1, buf equal %b want 1",
                         k, frame_valid, (img_buf === last_frame));
            end
        end
        pix_valid = 1'b0;
        do_ack();
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'd0;
        sb.push_back(model_frame(8'd1));
        feed(NPIX, 8'd1, 1'b0);
        for (int i = 0; i < NBITS; i++) zeros += int'(img_buf[i] == 1'b0);
        vectors++;
        if (zeros != NBITS) begin
            errors++;
            $display("FAIL zero_frame: got %0d zero bits want %0d", zeros, NBITS);
        end
        do_ack();
    endtask

    task automatic test_abort();
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'd200;
        feed(300, 8'd128, 1'b0);
        @(negedge clk);
        pix_valid   = 1'b1;
        pix_in      = 8'd200;
        frame_start = 1'b1;
        #1;
        vectors++;
        if (pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pix_ready: got %b want 0", pix_ready);
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        vectors++;
        if (img_buf[11 * W + 21] !== 1'b0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_accept: bit got %b want 0, frame_valid got %b want 0",
                     img_buf[11 * W + 21], frame_valid);
        end
        pos = 0;
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom);
        frame_pix[0] = 8'd0;
        sb.push_back(model_frame(8'd128));
        feed(1, 8'd128, 1'b0);
        vectors++;
        if (img_buf[W + 1] !== 1'b0 || img_buf[W + 2] !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart_bit: got (1,1)=%b (1,2)=%b want 0 1",
                     img_buf[W + 1], img_buf[W + 2]);
        end
        feed(NPIX - 1, 8'd128, 1'b1);
        do_ack();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom);
        feed(500, 8'd100, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (img_buf !== '0 || frame_valid !== 1'b0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: buf zero %b frame_valid %b pix_ready %b want 1 0 0",
                     (img_buf === '0), frame_valid, pix_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pos = 0;
        for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom);
        sb.push_back(model_frame(8'd100));
        feed(NPIX, 8'd100, 1'b1);
        do_ack();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pix_in      = '0;
        pix_valid   = 1'b0;
        bin_thresh  = '0;
        frame_start = 1'b0;
        frame_ack   = 1'b0;
        test_reset();
        test_const_frame();
        test_checker();
        test_thresh_equal();
        test_gaps();
        test_hold_full();
        test_abort();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
